// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Raster timing generator. It has a pixel-rate divider and registered
//            sync, blanking and coordinate decode, plus one-clock event strobes.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
   parameter int   DIV      = 4,
   parameter int   H_SYNC   = 96,
   parameter int   H_BACK   = 48,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FRONT  = 16,
   parameter int   V_SYNC   = 2,
   parameter int   V_BACK   = 33,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FRONT  = 10,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   W        = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [W-1:0] irq_line,
   output logic         pix_ce,
   output logic         hs,
   output logic         vs,
   output logic         draw,
   output logic [W-1:0] pix,
   output logic [W-1:0] line,
   output logic         line_start,
   output logic         frame_start,
   output logic         line_irq
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HA0     = H_SYNC + H_BACK;
   localparam int VA0     = V_SYNC + V_BACK;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [W-1:0]  H_LAST   = W'(H_TOTAL - 1);
   localparam logic [W-1:0]  V_LAST   = W'(V_TOTAL - 1);

   // Decode limits are one bit wider so an active end equal to 2**W cannot alias to 0.
   localparam logic [W:0] H_SYNC_E   = (W+1)'(H_SYNC);
   localparam logic [W:0] V_SYNC_E   = (W+1)'(V_SYNC);
   localparam logic [W:0] HA0_E      = (W+1)'(HA0);
   localparam logic [W:0] VA0_E      = (W+1)'(VA0);
   localparam logic [W:0] HA_END_E   = (W+1)'(HA0 + H_ACTIVE);
   localparam logic [W:0] VA_END_E   = (W+1)'(VA0 + V_ACTIVE);
   localparam logic [W:0] V_ACTIVE_E = (W+1)'(V_ACTIVE);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [W-1:0]  h_cnt_q, h_cnt_d;
   logic [W-1:0]  v_cnt_q, v_cnt_d;
   logic          tick;

   logic          pix_ce_q, pix_ce_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          draw_q, draw_d;
   logic [W-1:0]  pix_q, pix_d;
   logic [W-1:0]  line_q, line_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          line_irq_q, line_irq_d;

   logic [W:0]    h_e, v_e, irq_e;
   logic          h_act, v_act;

   assign h_e   = {1'b0, h_cnt_q};
   assign v_e   = {1'b0, v_cnt_q};
   assign irq_e = {1'b0, irq_line};

   always_comb begin
      div_cnt_d = div_cnt_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      tick      = enable && (div_cnt_q == DIV_LAST);
      if (enable) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      end
      if (tick) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   // Output decode follows the counters every cycle; the strobes mark the final
   // clock of the current position, which is the tick that advances it.
   always_comb begin
      h_act         = (h_e >= HA0_E) && (h_e < HA_END_E);
      v_act         = (v_e >= VA0_E) && (v_e < VA_END_E);
      draw_d        = h_act && v_act;
      hs_d          = (h_e < H_SYNC_E) ? HS_POL : ~HS_POL;
      vs_d          = (v_e < V_SYNC_E) ? VS_POL : ~VS_POL;
      pix_d         = '0;
      line_d        = '0;
      if (draw_d) begin
         pix_d  = W'(h_e - HA0_E);
         line_d = W'(v_e - VA0_E);
      end
      pix_ce_d      = tick;
      line_start_d  = tick && (h_cnt_q == '0);
      frame_start_d = line_start_d && (v_cnt_q == '0);
      line_irq_d    = line_start_d && (irq_e < V_ACTIVE_E) && (v_e == VA0_E + irq_e);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q     <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pix_ce_q      <= 1'b0;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         draw_q        <= 1'b0;
         pix_q         <= '0;
         line_q        <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         line_irq_q    <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pix_ce_q      <= pix_ce_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         draw_q        <= draw_d;
         pix_q         <= pix_d;
         line_q        <= line_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         line_irq_q    <= line_irq_d;
      end
   end

   assign pix_ce      = pix_ce_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign draw        = draw_q;
   assign pix         = pix_q;
   assign line        = line_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign line_irq    = line_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Checks three timing generator configurations against an arithmetic
//            raster model, then runs directed freeze, measurement and reset scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

   typedef struct packed {
      logic       ce, hs, vs, dr, ls, fs, li;
      logic [9:0] px, ln;
   } obs_t;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       enable   = 1'b0;
   logic [9:0] irq_line = 10'd2;
   bit         chk_on   = 1'b0;
   int         n_chk    = 0;
   int         n_pass   = 0;

   always #5 clk = ~clk;

   logic       a_ce, a_hs, a_vs, a_dr, a_ls, a_fs, a_li;
   logic [9:0] a_px, a_ln;
   logic       b_ce, b_hs, b_vs, b_dr, b_ls, b_fs, b_li;
   logic [5:0] b_px, b_ln;
   logic       c_ce, c_hs, c_vs, c_dr, c_ls, c_fs, c_li;
   logic [5:0] c_px, c_ln;

   vga_timing_gen u_a (
      .clk(clk), .rst(rst), .enable(enable), .irq_line(irq_line),
      .pix_ce(a_ce), .hs(a_hs), .vs(a_vs), .draw(a_dr), .pix(a_px), .line(a_ln),
      .line_start(a_ls), .frame_start(a_fs), .line_irq(a_li));

   vga_timing_gen #(
      .DIV(3), .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(1), .W(6)
   ) u_b (
      .clk(clk), .rst(rst), .enable(enable), .irq_line(irq_line[5:0]),
      .pix_ce(b_ce), .hs(b_hs), .vs(b_vs), .draw(b_dr), .pix(b_px), .line(b_ln),
      .line_start(b_ls), .frame_start(b_fs), .line_irq(b_li));

   vga_timing_gen #(
      .DIV(1), .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .W(6)
   ) u_c (
      .clk(clk), .rst(rst), .enable(enable), .irq_line(irq_line[5:0]),
      .pix_ce(c_ce), .hs(c_hs), .vs(c_vs), .draw(c_dr), .pix(c_px), .line(c_ln),
      .line_start(c_ls), .frame_start(c_fs), .line_irq(c_li));

   obs_t oa, ob, oc, ea, eb, ec;
   assign oa = {a_ce, a_hs, a_vs, a_dr, a_ls, a_fs, a_li, a_px, a_ln};
   assign ob = {b_ce, b_hs, b_vs, b_dr, b_ls, b_fs, b_li, 4'b0, b_px, 4'b0, b_ln};
   assign oc = {c_ce, c_hs, c_vs, c_dr, c_ls, c_fs, c_li, 4'b0, c_px, 4'b0, c_ln};

   // n = enabled clocks since reset before the current edge; the raster position
   // follows from n/div ticks, and the strobes fire on the edge that ends a pixel.
   function automatic obs_t model(input bit vld, input bit en, input longint n, input int dv,
                                  input int hsy, input int hbp, input int hac, input int hfp,
                                  input int vsy, input int vbp, input int vac, input int vfp,
                                  input bit hp, input bit vp, input int irq);
      obs_t   o;
      longint pos;
      int     ht, vt, h, v;
      bit     tk;
      o = '0;
      if (!vld) begin
         o.hs = ~hp;
         o.vs = ~vp;
         return o;
      end
      ht   = hsy + hbp + hac + hfp;
      vt   = vsy + vbp + vac + vfp;
      tk   = en && ((n % dv) == dv - 1);
      pos  = (n / dv) % (ht * vt);
      h    = int'(pos % ht);
      v    = int'(pos / ht);
      o.ce = tk;
      o.hs = (h < hsy) ? hp : ~hp;
      o.vs = (v < vsy) ? vp : ~vp;
      o.dr = (h >= hsy + hbp) && (h < hsy + hbp + hac) && (v >= vsy + vbp) && (v < vsy + vbp + vac);
      if (o.dr) begin
         o.px = 10'(h - hsy - hbp);
         o.ln = 10'(v - vsy - vbp);
      end
      o.ls = tk && (h == 0);
      o.fs = o.ls && (v == 0);
      o.li = o.ls && (irq < vac) && (v == vsy + vbp + irq);
      return o;
   endfunction

   function automatic obs_t mdef(input longint n, input bit en, input int irq);
      return model(1'b1, en, n, 4, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0, irq);
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   longint na = 0, nb = 0, nc = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         na <= 0;
         nb <= 0;
         nc <= 0;
         ea <= model(1'b0, 1'b0, 0, 4, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0, 0);
         eb <= model(1'b0, 1'b0, 0, 3, 4, 3, 8, 2, 2, 2, 5, 1, 1'b0, 1'b0, 0);
         ec <= model(1'b0, 1'b0, 0, 1, 4, 3, 8, 2, 2, 2, 5, 1, 1'b1, 1'b1, 0);
      end else begin
         ea <= model(1'b1, enable, na, 4, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0, int'(irq_line));
         eb <= model(1'b1, enable, nb, 3, 4, 3, 8, 2, 2, 2, 5, 1, 1'b0, 1'b0, int'(irq_line[5:0]));
         ec <= model(1'b1, enable, nc, 1, 4, 3, 8, 2, 2, 2, 5, 1, 1'b1, 1'b1, int'(irq_line[5:0]));
         if (enable) begin
            na <= na + 1;
            nb <= nb + 1;
            nc <= nc + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk_obs("cycle_a", oa, ea);
         chk_obs("cycle_b", ob, eb);
         chk_obs("cycle_c", oc, ec);
      end
   end

   int a_run = 0, a_last = 0, c_run = 0, c_last = 0;

   always @(negedge clk) begin
      if (a_hs == 1'b0) a_run <= a_run + 1;
      else if (a_run != 0) begin
         a_last <= a_run;
         a_run  <= 0;
      end
      if (c_hs == 1'b1) c_run <= c_run + 1;
      else if (c_run != 0) begin
         c_last <= c_run;
         c_run  <= 0;
      end
   end

   task automatic wait_na(input longint target, input string name);
      int k;
      k = 0;
      while (k < 20000 && na != target) begin
         @(negedge clk);
         k++;
      end
      if (na != target) chk(name, na, target);
   endtask

   task automatic measure_b(input string tag, input int exp_irq);
      int  k, ls, iq;
      bit  hit;
      hit = 1'b0;
      k   = 0;
      while (k < 2000 && !hit) begin
         @(negedge clk);
         k++;
         if (b_fs) hit = 1'b1;
      end
      chk({tag, "_sync"}, hit, 1);
      ls  = 1;
      iq  = 0;
      hit = 1'b0;
      k   = 0;
      while (k < 2000 && !hit) begin
         @(negedge clk);
         k++;
         if (b_fs) hit = 1'b1;
         else begin
            if (b_ls) ls++;
            if (b_li) iq++;
         end
      end
      chk({tag, "_frame_clk"}, k, 510);
      chk({tag, "_line_starts"}, ls, 10);
      chk({tag, "_line_irqs"}, iq, exp_irq);
   endtask

   initial begin : stim
      obs_t m, r_ab, r_c, frz;
      int   k, cnt;
      bit   hit;

      r_ab    = '0;
      r_ab.hs = 1'b1;
      r_ab.vs = 1'b1;
      r_c     = '0;
      frz     = '0;
      frz.hs  = 1'b1;

      #2;
      rst    = 1'b1;
      chk_on = 1'b1;
      repeat (3) @(negedge clk);
      chk_obs("reset_a", oa, r_ab);
      chk_obs("reset_b", ob, r_ab);
      chk_obs("reset_c", oc, r_c);

      m = mdef(112576, 1'b0, 2);
      chk("pin_first_draw", {m.dr, m.px, m.ln}, {1'b1, 10'd0, 10'd0});
      m = mdef(1647932, 1'b0, 2);
      chk("pin_last_draw", {m.dr, m.px, m.ln}, {1'b1, 10'd639, 10'd479});
      m = mdef(1647936, 1'b0, 2);
      chk("pin_h784_blank", {m.dr, m.px, m.ln}, 0);
      m = mdef(1648576, 1'b0, 2);
      chk("pin_v515_blank", {m.dr, m.px, m.ln}, 0);
      m = mdef(380, 1'b0, 2);
      chk("pin_hs_h95", m.hs, 0);
      m = mdef(384, 1'b0, 2);
      chk("pin_hs_h96", m.hs, 1);
      m = mdef(432003, 1'b1, 100);
      chk("pin_irq100", {m.ls, m.li}, 2'b11);
      m = mdef(1648003, 1'b1, 480);
      chk("pin_irq480", {m.ls, m.li}, 2'b10);
      m = mdef(1680003, 1'b1, 2);
      chk("pin_frame_wrap", {m.ce, m.fs}, 2'b11);

      rst    = 1'b0;
      enable = 1'b1;

      // freeze in the middle of pixel 300 of the first line
      wait_na(1201, "wait_h300");
      enable = 1'b0;
      repeat (1000) @(negedge clk);
      chk_obs("freeze_a", oa, frz);
      enable = 1'b1;
      k   = 0;
      hit = 1'b0;
      while (k < 10 && !hit) begin
         @(negedge clk);
         k++;
         if (a_ce) hit = 1'b1;
      end
      chk("resume_latency", k, 3);

      wait_na(3680, "wait_line1");
      chk("a_hs_low_clk", a_last, 384);
      chk("c_hs_high_clk", c_last, 4);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (c_ce) cnt++;
      end
      chk("c_pix_ce_cont", cnt, 50);

      irq_line = 10'd2;
      measure_b("b_irq2", 1);
      irq_line = 10'd5;
      measure_b("b_irq5", 0);

      // reset mid-frame at raster position v=5, h=6 of instance B
      k = 0;
      while (k < 3000 && !(((nb / 3) % 170 == 91) && (nb % 3 == 0))) begin
         @(negedge clk);
         k++;
      end
      chk("wait_b_midframe", (nb / 3) % 170, 91);
      #2;
      rst = 1'b1;
      #1;
      chk_obs("async_rst_a", oa, r_ab);
      chk_obs("async_rst_b", ob, r_ab);
      chk_obs("async_rst_c", oc, r_c);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("c_first_fs", {c_ce, c_fs}, 2'b11);
      k   = 1;
      hit = b_fs;
      while (k < 10 && !hit) begin
         @(negedge clk);
         k++;
         if (b_fs) hit = 1'b1;
      end
      chk("b_first_fs_clk", k, 3);

      repeat (20) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter DIV, default 4: CLK cycles per pixel; range 1..16.
REQ-002 Parameters H_SYNC 96, H_BACK 48, H_ACTIVE 640, H_FRONT 16: horizontal segment lengths in pixels.
REQ-003 Parameters V_SYNC 2, V_BACK 33, V_ACTIVE 480, V_FRONT 10: vertical segment lengths in lines.
REQ-004 Parameters HS_POL 0, VS_POL 0: active level of HS and VS.
REQ-005 Parameter W, default 10: counter and coordinate width; H_TOTAL and V_TOTAL are each at most 2^W.
REQ-006 CLK  in  1  system clock; all state changes on its rising edge.
REQ-007 RST  in  1  asynchronous, active-high reset.
REQ-008 ENABLE  in  1  high: timing runs; low: all counters hold.
REQ-009 IRQ_LINE  in  W  active-line index on which LINE_IRQ fires.
REQ-010 PIX_CE  out  1  one-CLK pixel strobe, aligned with the outputs below.
REQ-011 HS, VS  out  1 each  sync outputs at parameterised polarity.
REQ-012 DRAW  out  1  high inside the active area.
REQ-013 PIX, LINE  out  W each  active coordinates; 0 outside the active area.
REQ-014 LINE_START, FRAME_START, LINE_IRQ  out  1 each  one-CLK event pulses, qualified by PIX_CE.

Function
REQ-015 Derived totals: H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT; V_TOTAL is formed the same way from the V parameters.
REQ-016 Divider div_cnt counts 0..DIV-1 while ENABLE is high; tick = ENABLE & (div_cnt == DIV-1); DIV=1 gives tick = ENABLE.
REQ-017 On tick, h_cnt increments and wraps from H_TOTAL-1 to 0; on that wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
REQ-018 Segment order per line is sync, back porch, active, front porch; vertical uses the same order.
REQ-019 HS asserted iff h_cnt < H_SYNC; VS asserted iff v_cnt < V_SYNC.
REQ-020 DRAW high iff HA0 <= h_cnt < HA0+H_ACTIVE and VA0 <= v_cnt < VA0+V_ACTIVE, where HA0 = H_SYNC+H_BACK and VA0 = V_SYNC+V_BACK; both upper bounds are strict.
REQ-021 PIX = h_cnt-HA0 and LINE = v_cnt-VA0 when DRAW is high; both are 0 otherwise; arithmetic is W bits wide with no wrap.
REQ-022 LINE_START high iff h_cnt==0; FRAME_START high iff h_cnt==0 and v_cnt==0; LINE_IRQ high iff h_cnt==0 and v_cnt==VA0+IRQ_LINE.
REQ-023 All three pulses are gated by PIX_CE, so each lasts exactly one CLK per event.
REQ-024 Outputs are registered decodes of the counters: one CLK latency from a counter update to the matching outputs; PIX_CE is tick delayed by one CLK.
REQ-025 Between PIX_CE pulses, every output holds its value.
REQ-026 ENABLE low: div_cnt, h_cnt and v_cnt hold; PIX_CE and all pulses are 0; HS, VS, DRAW, PIX and LINE hold.
REQ-027 ENABLE high again: the divider resumes from its held value and no tick is lost or duplicated.
REQ-028 IRQ_LINE >= V_ACTIVE: LINE_IRQ never fires.
REQ-029 IRQ_LINE is sampled only at h_cnt==0, so changes mid-line take effect on the next line.

Reset
REQ-030 RST high asynchronously clears div_cnt, h_cnt and v_cnt to 0.
REQ-031 RST high forces HS=~HS_POL, VS=~VS_POL, DRAW=0, PIX=0, LINE=0 and PIX_CE=LINE_START=FRAME_START=LINE_IRQ=0.
REQ-032 On the first CLK edge after RST falls, outputs reflect counter position (0,0); the first FRAME_START follows the first tick plus one CLK.
REQ-033 RST asserted mid-frame takes effect immediately; no partial line or pulse completes.

Verification
REQ-034 Defaults, ENABLE=1: HS low for 96 PIX_CE = 384 CLK per line; VS low for exactly 2 lines = 1600 ticks.
REQ-035 Defaults: first DRAW at h=144 with PIX=0, last DRAW at h=783 with PIX=639 and LINE=479 on v=514; DRAW=0 at h=784 and at v=515.
REQ-036 Defaults: successive FRAME_START pulses are 420000 ticks = 1,680,000 CLK apart; exactly 525 LINE_START pulses per frame.
REQ-037 IRQ_LINE=100: one LINE_IRQ per frame, at v=135, h=0; IRQ_LINE=480: no LINE_IRQ.
REQ-038 ENABLE low for 1000 CLK mid-line at h=300: counters and outputs frozen; after release, h=301 appears after the remaining divider cycles, with no skipped pixel.
REQ-039 RST pulse at v=200, h=400, and a separate run with DIV=1, HS_POL=1, VS_POL=1: after reset, outputs return to REQ-031 values and the next frame starts at (0,0); with DIV=1, PIX_CE is continuously high and HS is high for 96 CLK.
